// File: rtl/skid_buf_pkg.sv
// Shared types for the two-entry skid buffer: occupancy state encoding and depth.
package skid_buf_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/skid_buffer_reader_reg_en_bus.sv
// Enabled register bank for skid buffer payloads; one cycle load latency, no handshake.
// Synchronous active-high reset clears every bit; en gates loads.
module reg_en_bit (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= 1'b0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

module reg_en_bus #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    reg_en_bit u_bit (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .d     (in[i]),
      .q     (out[i])
    );
  end

endmodule

// File: rtl/skid_buffer_reader.sv
// Two-entry valid/ready skid buffer, one cycle in-to-out latency; ready/valid decode from state only.
// Optional SKID_BUF_FLUSH_EN adds a flush input that empties the buffer (reset still wins).
module skid_buffer_reader
  import skid_buf_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef SKID_BUF_FLUSH_EN
  input  logic             flush,
`endif
  output logic [WIDTH-1:0] out_data
);

  skid_state_t      state;
  skid_state_t      state_nxt;
  logic             in_fire;
  logic             out_fire;
  logic             main_en;
  logic             skid_en;
  logic             main_from_skid;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_q;

  // Ready/valid come straight off the state flops so neither side sees a combinational path.
  assign out_valid = (state != EMPTY);
  assign in_ready  = (state != FULL);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_nxt      = state;
    main_en        = 1'b0;
    skid_en        = 1'b0;
    main_from_skid = 1'b0;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          main_en   = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          main_en = 1'b1;
        end else if (in_fire) begin
          skid_en   = 1'b1;
          state_nxt = FULL;
        end else if (out_fire) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          main_en        = 1'b1;
          main_from_skid = 1'b1;
          state_nxt      = BUSY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
`ifdef SKID_BUF_FLUSH_EN
    // Squash drops held entries and any coincident upstream beat; data flops keep stale bits.
    if (flush) begin
      state_nxt = EMPTY;
      main_en   = 1'b0;
      skid_en   = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  assign main_d = main_from_skid ? skid_q : in_data;

  reg_en_bus #(.WIDTH(WIDTH)) u_main (
    .clk   (clk),
    .reset (reset),
    .en    (main_en),
    .in    (main_d),
    .out   (out_data)
  );

  reg_en_bus #(.WIDTH(WIDTH)) u_skid (
    .clk   (clk),
    .reset (reset),
    .en    (skid_en),
    .in    (in_data),
    .out   (skid_q)
  );

endmodule

// File: tb/tb_skid_buffer_reader.sv
// Self-checking bench for skid_buffer_reader: directed scenarios plus randomized traffic
// against a queue-based FIFO reference model.
module tb_skid_buffer_reader;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        flush;

  int n_cmp;
  int n_err;
  logic [31:0] mq[$];

  skid_buffer_reader #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef SKID_BUF_FLUSH_EN
    .flush     (flush),
`endif
    .out_data  (out_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock; the model is a plain FIFO of at most two entries.
  task automatic tick();
    bit inf;
    bit outf;
    inf  = in_valid && (mq.size() < 2);
    outf = out_ready && (mq.size() > 0);
    @(posedge clk);
    if (reset) begin
      mq.delete();
    end else begin
`ifdef SKID_BUF_FLUSH_EN
      if (flush) begin
        mq.delete();
        inf  = 1'b0;
        outf = 1'b0;
      end
`endif
      if (outf) void'(mq.pop_front());
      if (inf) mq.push_back(in_data);
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; flush = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL reset_out_data: got %h want 0", out_data); end
  endtask

  task automatic test_single_pass();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'hA5A5_0001;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 32'hA5A5_0001) begin n_err++; $display("FAIL single_data: got %h want a5a50001", out_data); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL single_ready: got %b want 1", in_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_fill_stall();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11;
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h11) begin n_err++; $display("FAIL fill_first: got v=%b d=%h want v=1 d=11", out_valid, out_data); end
    in_data = 32'h22;
    tick();
    in_valid = 1'b0; in_data = 32'hDEAD_BEEF;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fill_full_ready: got %b want 0", in_ready); end
    n_cmp++; if (out_data !== 32'h11) begin n_err++; $display("FAIL fill_head: got %h want 11", out_data); end
    tick();
    n_cmp++; if (out_data !== 32'h11 || out_valid !== 1'b1) begin n_err++; $display("FAIL stall_hold: got v=%b d=%h want v=1 d=11", out_valid, out_data); end
    out_ready = 1'b1;
    tick();
    n_cmp++; if (out_data !== 32'h22 || out_valid !== 1'b1) begin n_err++; $display("FAIL pop_second: got v=%b d=%h want v=1 d=22", out_valid, out_data); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL pop_ready: got %b want 1", in_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL pop_empty: got %b want 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 32'(i);
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_data !== 32'(i)) begin
        n_err++;
        $display("FAIL stream_%0d: got v=%b r=%b d=%h want v=1 r=1 d=%h", i, out_valid, in_ready, out_data, 32'(i));
      end
    end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_drain: got %b want 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h33;
    tick();
    in_data = 32'h44;
    tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL mreset_full: got %b want 0", in_ready); end
    in_data = 32'h77; reset = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL mreset_state: got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
    n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL mreset_data: got %h want 0", out_data); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mreset_ghost_%0d: got v=%b d=%h want v=0", i, out_valid, out_data); end
    end
    out_ready = 1'b0;
  endtask

`ifdef SKID_BUF_FLUSH_EN
  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h66;
    tick();
    in_data = 32'h67;
    tick();
    in_data = 32'h55; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL flush_state: got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
    out_ready = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_lost_beat: got v=%b d=%h want v=0", out_valid, out_data); end
    out_ready = 1'b0;
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = $urandom;
      reset     = ($urandom_range(0, 63) == 0);
`ifdef SKID_BUF_FLUSH_EN
      flush     = ($urandom_range(0, 31) == 0);
`endif
      n_cmp++;
      if (out_valid !== (mq.size() != 0) || in_ready !== (mq.size() < 2)) begin
        n_err++;
        $display("FAIL rand_flags_%0d: got v=%b r=%b want v=%b r=%b", c, out_valid, in_ready, mq.size() != 0, mq.size() < 2);
      end
      if (mq.size() != 0) begin
        n_cmp++;
        if (out_data !== mq[0]) begin n_err++; $display("FAIL rand_data_%0d: got %h want %h", c, out_data, mq[0]); end
      end
      tick();
    end
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; flush = 1'b0;
    test_reset();
    test_single_pass();
    test_fill_stall();
    test_streaming();
    test_mid_reset();
`ifdef SKID_BUF_FLUSH_EN
    test_flush();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
